uart_tx_core: RTL and testbench

//  UART transmitter: serializes one 8-bit word per request into a frame of

---
 rtl/uart_tx_core.sv | 119 +++++++++++
 tb/tb_uart_tx_core.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, one stop bit.
// Latency: TX_OUT and Busy change one cycle after Data_Valid is accepted; a frame is (10 + PAR_EN) * Prescale cycles.
// Backpressure: Data_Valid is accepted only while idle; requests made while Busy is high are dropped, not queued.
module uart_tx_core #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [7:0]            Prescale,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]            state_q,   state_d;
    logic [7:0]            edge_q,    edge_d;
    logic [2:0]            bit_q,     bit_d;
    logic [DATA_WIDTH-1:0] data_q,    data_d;
    logic                  par_en_q,  par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic [7:0]            presc_q,   presc_d;
    logic                  tx_q,      tx_d;
    logic                  busy_q,    busy_d;
    logic                  term;

    // Last cycle of the current bit period; with a prescale of 1 this is every cycle.
    assign term = (edge_q == (presc_q - 8'd1));

    // Next-state, counter and latch logic; TX_OUT is registered from the next state so it never glitches.
    always_comb begin
        state_d   = state_q;
        edge_d    = edge_q;
        bit_d     = bit_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        presc_d   = presc_q;
        tx_d      = 1'b1;

        if (state_q == S_IDLE) begin
            edge_d = 8'd0;
            bit_d  = 3'd0;
            if (Data_Valid) begin
                data_d    = P_DATA;
                par_en_d  = PAR_EN;
                par_bit_d = (^P_DATA) ^ PAR_TYP;
                presc_d   = (Prescale == 8'd0) ? 8'd1 : Prescale;
                state_d   = S_START;
            end
        end else begin
            edge_d = term ? 8'd0 : (edge_q + 8'd1);
            if (term) begin
                case (state_q)
                    S_START: begin
                        state_d = S_DATA;
                        bit_d   = 3'd0;
                    end
                    S_DATA: begin
                        if (bit_q == 3'd7) begin
                            state_d = par_en_q ? S_PARITY : S_STOP;
                            bit_d   = 3'd0;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                    S_PARITY: state_d = S_STOP;
                    default:  state_d = S_IDLE;
                endcase
            end
        end

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = data_d[bit_d];
            S_PARITY: tx_d = par_bit_d;
            default:  tx_d = 1'b1;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State registers; reset abandons any frame in flight and returns the line to idle-high.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            edge_q    <= 8'd0;
            bit_q     <= 3'd0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            presc_q   <= 8'd1;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            edge_q    <= edge_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            presc_q   <= presc_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: frames are checked bit by bit, cycle by cycle.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Every expected bit comes from hand-chosen data and parity constants.
module tb_uart_tx_core;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] Prescale;
    logic       TX_OUT;
    logic       Busy;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_core #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Present a request at a falling edge, hold it across one rising edge, return at the next falling edge.
    task automatic accept(input logic [7:0] d, input logic pe, input logic pt, input logic [7:0] ps);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Prescale   = ps;
        Data_Valid = 1'b1;
        @(posedge CLK);
        #1;
        Data_Valid = 1'b0;
        @(negedge CLK);
    endtask

    // Called at the first falling edge after accept; checks every cycle of the frame and the idle cycle after it.
    task automatic expect_frame(input string tag, input logic [7:0] d, input logic pe,
                                input logic pb, input int pl);
        logic bits [0:10];
        int   nb;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        nb = 9;
        if (pe) begin
            bits[nb] = pb;
            nb++;
        end
        bits[nb] = 1'b1;
        nb++;
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < pl; c++) begin
                check($sformatf("%s tx bit%0d cyc%0d", tag, b, c), TX_OUT, bits[b]);
                check($sformatf("%s busy bit%0d cyc%0d", tag, b, c), Busy, 1'b1);
                @(negedge CLK);
            end
        end
        check({tag, " busy after frame"}, Busy, 1'b0);
        check({tag, " tx idle after frame"}, TX_OUT, 1'b1);
    endtask

    initial begin
        RST        = 1'b1;
        P_DATA     = 8'h00;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Prescale   = 8'd1;
        repeat (3) @(negedge CLK);
        check("reset tx", TX_OUT, 1'b1);
        check("reset busy", Busy, 1'b0);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("idle tx", TX_OUT, 1'b1);
        check("idle busy", Busy, 1'b0);

        // 1: prescale 8, no parity, 0xA5 -> 80 busy cycles
        accept(8'hA5, 1'b0, 1'b0, 8'd8);
        expect_frame("t1", 8'hA5, 1'b0, 1'b0, 8);

        // 2: prescale 4 with parity
        accept(8'hA5, 1'b1, 1'b0, 8'd4);
        expect_frame("t2even", 8'hA5, 1'b1, 1'b0, 4);
        accept(8'hA5, 1'b1, 1'b1, 8'd4);
        expect_frame("t2odd", 8'hA5, 1'b1, 1'b1, 4);
        accept(8'h07, 1'b1, 1'b0, 8'd4);
        expect_frame("t2x07", 8'h07, 1'b1, 1'b1, 4);

        // 3: Data_Valid held high, data changes mid-frame; second frame one idle cycle after Busy falls
        P_DATA     = 8'h3A;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Prescale   = 8'd2;
        Data_Valid = 1'b1;
        @(posedge CLK);
        #1;
        P_DATA = 8'hC6;
        @(negedge CLK);
        expect_frame("t3first", 8'h3A, 1'b0, 1'b0, 2);
        @(posedge CLK);
        #1;
        Data_Valid = 1'b0;
        @(negedge CLK);
        expect_frame("t3second", 8'hC6, 1'b0, 1'b0, 2);

        // 4: prescale 0 and 1 both give one cycle per bit
        accept(8'h55, 1'b0, 1'b0, 8'd0);
        expect_frame("t4p0", 8'h55, 1'b0, 1'b0, 1);
        accept(8'h55, 1'b0, 1'b0, 8'd1);
        expect_frame("t4p1", 8'h55, 1'b0, 1'b0, 1);

        // 5: reset during data bit 3 (cycles 16..19 of a prescale-4 frame)
        accept(8'h08, 1'b0, 1'b0, 8'd4);
        repeat (16) @(negedge CLK);
        check("t5 tx in bit3", TX_OUT, 1'b1);
        check("t5 busy in bit3", Busy, 1'b1);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("t5 tx after reset", TX_OUT, 1'b1);
        check("t5 busy after reset", Busy, 1'b0);
        @(negedge CLK);
        check("t5 still idle", Busy, 1'b0);
        accept(8'h96, 1'b1, 1'b1, 8'd3);
        expect_frame("t5clean", 8'h96, 1'b1, 1'b1, 3);

        // 6: prescale/data changes mid-frame do not affect the frame in flight
        accept(8'h3C, 1'b0, 1'b0, 8'd8);
        Prescale = 8'd2;
        P_DATA   = 8'hFF;
        PAR_EN   = 1'b1;
        expect_frame("t6p8", 8'h3C, 1'b0, 1'b0, 8);
        accept(8'hC3, 1'b0, 1'b0, 8'd2);
        expect_frame("t6p2", 8'hC3, 1'b0, 1'b0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
